trig_capture_ctrl: RTL
======================

Name: trig_capture_ctrl

Overview:
- Downstream consumer of the protocol-trigger output (protTrig) in the logic-analyzer trigger path.
- Qualifies protTrig with per-channel level/edge triggers and the capture unit's armed status.
- Sequences a capture run: pre-trigger fill, trigger, post-trigger sample count, done.
- Drives the triggered / capture_done flags and the sample-RAM write enable.

Parameters:
- CH_N, 5, number of per-channel trigger inputs.
- POS_W, 9, width of the post-trigger sample count (trig_pos, post_cnt).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- run  input  1  level; capture run requested (from cmd_cfg).
- armed  input  1  capture buffer has filled the pre-trigger region.
- ch_trig  input  CH_N  per-channel trigger conditions, already edge/level qualified upstream.
- ch_en  input  CH_N  1 = channel participates in the trigger AND.
- protTrig  input  1  protocol trigger (SPI/UART combined).
- smpl_en  input  1  one-cycle strobe per decimated sample.
- trig_pos  input  POS_W  number of samples to capture after the trigger.
- clr_done  input  1  pulse; acknowledges capture_done (from cmd_cfg after readout).
- triggered  output  1  trigger has occurred in this run.
- capture_done  output  1  post-trigger capture complete.
- wrt_smpl  output  1  write-enable to sample RAM.
- post_cnt  output  POS_W  post-trigger samples written so far.
- state_o  output  3  current state encoding, for debug readback.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, post_cnt=0.
  - triggered=0, capture_done=0, wrt_smpl=0.
- Trigger condition: trig_cond = protTrig & (&(ch_trig | ~ch_en)). With ch_en=0, trig_cond = protTrig.
- State encoding: IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4.
- State transitions (all registered):
  - IDLE -> FILL when run=1.
  - FILL -> ARMED when armed=1.
  - ARMED -> POST when trig_cond=1. post_cnt cleared to 0 on this transition.
  - ARMED -> DONE directly when trig_cond=1 and trig_pos=0 (zero post samples).
  - POST: on each smpl_en, post_cnt increments. When smpl_en=1 and post_cnt==trig_pos-1, go to DONE; post_cnt ends at trig_pos.
  - DONE -> IDLE on clr_done=1.
  - DONE holds indefinitely otherwise, even if run=0.
- Abort: run=0 in FILL, ARMED or POST returns to IDLE next cycle. triggered is cleared, post_cnt is held for readback.
- Trigger timing:
  - Trigger is evaluated only in ARMED. trig_cond in IDLE or FILL is ignored (no latching).
  - trig_cond and run=0 in the same ARMED cycle: abort wins.
- wrt_smpl = smpl_en & (state is FILL, ARMED or POST). Combinational from the registered state; 0 in IDLE and DONE.
- Output flags:
  - triggered = 1 in POST and DONE, registered. Asserts the cycle after trig_cond is seen.
  - capture_done = 1 only in DONE. Asserts one cycle after the final post sample is written.
- clr_done outside DONE has no effect.
- run=1 held through DONE does not restart the run until clr_done is pulsed. After clr_done, IDLE -> FILL happens on the next cycle if run is still 1.
- post_cnt wraps only if trig_pos = 2^POS_W-1 is exceeded; this is impossible by construction because the terminal compare stops counting.
- Reset mid-run: returns to IDLE with all outputs 0 on the same edge.

Optional Feature:
- Macro: TRIG_QUALIFY_EN.
- Defined: trig_cond must be 1 on two consecutive smpl_en strobes while in ARMED before the ARMED -> POST transition.
  - Uses a 1-bit qualifier register, cleared on leaving ARMED.
  - A single-sample glitch does not trigger.
- Undefined: trigger is taken on the first cycle trig_cond=1, as described in Behaviour.

Test Plan:
1. Basic run, trig_pos=4, ch_en=0:
   - Stimulus: run=1; armed after 10 samples; protTrig pulse.
   - Required: triggered=1 the next cycle; exactly 4 wrt_smpl in POST; capture_done=1 with post_cnt=4; clr_done -> IDLE.
2. Channel gating, ch_en=5'b00101:
   - ch_trig=5'b00001, protTrig=1 -> no trigger.
   - ch_trig=5'b00101, protTrig=1 -> POST.
3. trig_pos=0:
   - trig_cond in ARMED -> DONE the next cycle, zero POST writes, post_cnt=0.
4. Early trigger:
   - Stimulus: protTrig=1 during FILL, before armed; then dropped before armed rises.
   - Required: stays ARMED, triggered=0.
5. Abort:
   - run=0 at post_cnt=2 of trig_pos=8 -> IDLE next cycle, triggered=0, wrt_smpl=0, capture_done never set.
   - Synchronous rst_n=0 in POST -> all outputs 0 on that edge.
6. With TRIG_QUALIFY_EN:
   - trig_cond high for 1 strobe -> no trigger.
   - trig_cond high for 2 consecutive strobes -> POST after the second.

Source files
------------

// File: rtl/trig_capture_ctrl_if.sv
// Bundle of the capture controller's run/trigger inputs and its status outputs.
// The controller connects through the slave modport; whoever drives run/trigger
// inputs (command/config block, or a bench) connects through the master modport.
interface trig_capture_ctrl_if #(
  parameter int CH_N  = 5,
  parameter int POS_W = 9
);
  logic              run;
  logic              armed;
  logic [CH_N-1:0]   ch_trig;
  logic [CH_N-1:0]   ch_en;
  logic              protTrig;
  logic              smpl_en;
  logic [POS_W-1:0]  trig_pos;
  logic              clr_done;
  logic              triggered;
  logic              capture_done;
  logic              wrt_smpl;
  logic [POS_W-1:0]  post_cnt;
  logic [2:0]        state_o;

  modport master (
    output run, armed, ch_trig, ch_en, protTrig, smpl_en, trig_pos, clr_done,
    input  triggered, capture_done, wrt_smpl, post_cnt, state_o
  );

  modport slave (
    input  run, armed, ch_trig, ch_en, protTrig, smpl_en, trig_pos, clr_done,
    output triggered, capture_done, wrt_smpl, post_cnt, state_o
  );
endinterface

// File: rtl/trig_capture_ctrl.sv
// Capture-run sequencer for the logic-analyzer trigger path.
// Qualifies protTrig with the enabled per-channel triggers, walks a run through
// pre-trigger fill, armed, post-trigger counting and done, and produces the
// sample-RAM write enable plus triggered/capture_done status.
// Optional build macro TRIG_QUALIFY_EN: when defined, the trigger condition must
// hold on two consecutive sample strobes in ARMED before the trigger is taken.
module trig_capture_ctrl #(
  parameter int CH_N  = 5,
  parameter int POS_W = 9
) (
  input logic              clk,
  input logic              rst_n,
  trig_capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [POS_W-1:0]  post_cnt_q, post_cnt_d;
  logic [POS_W-1:0]  cnt_inc;
  logic [CH_N-1:0]   ch_ok;
  logic              trig_cond;
  logic              take_trig;

  // A disabled channel never blocks the trigger; enabled channels must all agree.
  assign ch_ok     = bus.ch_trig | ~bus.ch_en;
  assign trig_cond = bus.protTrig & (&ch_ok);
  assign cnt_inc   = post_cnt_q + POS_W'(1);

`ifdef TRIG_QUALIFY_EN
  logic qual_q, qual_d;

  // The trigger fires only on a strobe whose predecessor strobe also saw trig_cond.
  assign take_trig = bus.smpl_en & trig_cond & qual_q;

  // Remember whether the last strobe in ARMED saw trig_cond; forget it outside ARMED.
  always_comb begin
    qual_d = qual_q;
    if (state_q == ARMED && bus.smpl_en) begin
      qual_d = trig_cond;
    end
    if (state_d != ARMED) begin
      qual_d = 1'b0;
    end
  end

  // Qualifier register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qual_q <= 1'b0;
    end else begin
      qual_q <= qual_d;
    end
  end
`else
  assign take_trig = trig_cond;
`endif

  // Next-state and post-trigger counter; run dropping aborts any active phase.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FILL;
      end
      FILL: begin
        if (!bus.run)       state_d = IDLE;
        else if (bus.armed) state_d = ARMED;
      end
      ARMED: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (take_trig) begin
          post_cnt_d = '0;
          state_d    = (bus.trig_pos == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (bus.smpl_en) begin
          post_cnt_d = cnt_inc;
          if (cnt_inc == bus.trig_pos) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.clr_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  assign bus.triggered    = (state_q == POST) || (state_q == DONE);
  assign bus.capture_done = (state_q == DONE);
  assign bus.wrt_smpl     = bus.smpl_en &
                            ((state_q == FILL) || (state_q == ARMED) || (state_q == POST));
  assign bus.post_cnt     = post_cnt_q;
  assign bus.state_o      = state_q;

endmodule
